// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle RV32I ops plus iterative M-extension ops.
// Define ALU_MEXT_EN to build the multiply/divide datapath and the CALC state.
module alu_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IMM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [XLEN-1:0]  src_a,
    input  logic [XLEN-1:0]  src_b,
    input  logic [IMM_W-1:0] imm,
    input  logic             use_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             busy
);

    localparam int unsigned SW = $clog2(XLEN);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDone = 2'd1
`ifdef ALU_MEXT_EN
        , StCalc = 2'd2
`endif
    } state_t;

    state_t          state_q, state_d;
    logic            accept;
    logic [XLEN-1:0] b_eff;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] result_q, result_d;

    assign accept = in_valid && in_ready;
    assign b_eff  = use_imm ? {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm} : src_b;
    assign shamt  = b_eff[SW-1:0];
    assign result = result_q;

    always_comb begin
        alu_res = '0;
        case (op)
            5'd0:    alu_res = src_a + b_eff;
            5'd1:    alu_res = src_a - b_eff;
            5'd2:    alu_res = src_a << shamt;
            5'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(b_eff)};
            5'd4:    alu_res = {{(XLEN-1){1'b0}}, src_a < b_eff};
            5'd5:    alu_res = src_a ^ b_eff;
            5'd6:    alu_res = src_a >> shamt;
            5'd7:    alu_res = $signed(src_a) >>> shamt;
            5'd8:    alu_res = src_a | b_eff;
            5'd9:    alu_res = src_a & b_eff;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MEXT_EN
    logic            is_mext, is_div, sgn_a, sgn_b, a_neg, b_neg;
    logic            b_zero, div_ovf, fast, start_iter, last;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, dv_q;
    logic [SW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic            neg_q, rneg_q;
    logic [XLEN:0]   sum, shifted, diff;
    logic            ge;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] q_s, r_s, iter_res;

    assign is_mext = (op[4:3] == 2'b10);
    assign is_div  = op[2];
    // Ops 20/22 are signed divides; 17 is signed x signed, 18 signed x unsigned.
    assign sgn_a   = is_div ? ~op[0] : (op[1:0] == 2'd1 || op[1:0] == 2'd2);
    assign sgn_b   = is_div ? ~op[0] : (op[1:0] == 2'd1);
    assign a_neg   = sgn_a && src_a[XLEN-1];
    assign b_neg   = sgn_b && b_eff[XLEN-1];
    assign mag_a   = a_neg ? -src_a : src_a;
    assign mag_b   = b_neg ? -b_eff : b_eff;

    assign b_zero   = (b_eff == '0);
    assign div_ovf  = ~op[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (b_eff == '1);
    assign fast     = is_mext && is_div && (b_zero || div_ovf);
    assign fast_res = b_zero ? (op[1] ? src_a : '1) : (op[1] ? '0 : src_a);
    assign start_iter = accept && is_mext && !fast;
    assign last       = (state_q == StCalc) && (cnt_q == SW'(XLEN-1));

    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, dv_q};
        ge      = ~diff[XLEN];
        if (op_q[2]) begin
            hi_d = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ge};
        end else begin
            {hi_d, lo_d} = {sum, lo_q[XLEN-1:1]};
        end
        prod_s = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
        q_s    = neg_q ? -lo_d : lo_d;
        r_s    = rneg_q ? -hi_d : hi_d;
        if (op_q[2]) begin
            iter_res = op_q[1] ? r_s : q_s;
        end else begin
            iter_res = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            dv_q   <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else if (start_iter) begin
            hi_q   <= '0;
            lo_q   <= is_div ? mag_a : mag_b;
            dv_q   <= is_div ? mag_b : mag_a;
            cnt_q  <= '0;
            op_q   <= op[2:0];
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
        end else if (state_q == StCalc) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        result_d = result_q;
        if (accept) begin
`ifdef ALU_MEXT_EN
            if (fast) begin
                result_d = fast_res;
            end else if (!is_mext) begin
                result_d = alu_res;
            end
`else
            result_d = alu_res;
`endif
        end
`ifdef ALU_MEXT_EN
        if (last) begin
            result_d = iter_res;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
`ifdef ALU_MEXT_EN
                    state_d = start_iter ? StCalc : StDone;
`else
                    state_d = StDone;
`endif
                end else if (state_q == StDone && out_ready) begin
                    state_d = StIdle;
                end
            end
`ifdef ALU_MEXT_EN
            StCalc: begin
                if (last) begin
                    state_d = StDone;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid = (state_q == StDone);
        in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
`ifdef ALU_MEXT_EN
        busy      = (state_q == StCalc);
`else
        busy      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (XLEN=32); M-extension cases follow ALU_MEXT_EN.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [11:0] imm;
    logic        use_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_seq #(.XLEN(32), .IMM_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .imm       (imm),
        .use_imm   (use_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op for one edge; caller guarantees in_ready. Returns 1 ns after the edge.
    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [11:0] i, input logic ui);
        op = o; src_a = a; src_b = b; imm = i; use_imm = ui;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678; op = 5'd1; imm = 12'h0;
    endtask

    // Cycles from the accept edge until out_valid is seen, bounded at 100.
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic idle();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    endtask

    task automatic test_add_sub();
        int n;
        issue(5'd0, 32'd5, 32'd4, 12'h0, 1'b0);
        wait_valid(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", n); end
        checks++; if (result !== 32'd9) begin errors++; $display("FAIL add got %h want 9", result); end
        issue(5'd1, 32'd5, 32'd0, 12'hFFF, 1'b1);
        wait_valid(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL sub_latency got %0d want 1", n); end
        checks++; if (result !== 32'd6) begin errors++; $display("FAIL sub_imm got %h want 6", result); end
    endtask

    task automatic test_single_ops();
        logic [4:0]  ops  [9] = '{5'd7, 5'd4, 5'd3, 5'd2, 5'd6, 5'd8, 5'd5, 5'd0, 5'd10};
        logic [31:0] as   [9] = '{32'h8000_0000, 32'd1, 32'd1, 32'd1, 32'h8000_0000,
                                  32'hF0, 32'hFF, 32'hFFFF_FFFF, 32'h1234};
        logic [31:0] bs   [9] = '{32'h24, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd33, 32'd4,
                                  32'h0F, 32'h0F, 32'd1, 32'h1};
        logic [31:0] exps [9] = '{32'hF800_0000, 32'd1, 32'd0, 32'd2, 32'h0800_0000,
                                  32'hFF, 32'hF0, 32'h0, 32'h0};
        int n;
        for (int k = 0; k < 9; k++) begin
            issue(ops[k], as[k], bs[k], 12'h0, 1'b0);
            wait_valid(n);
            checks++;
            if (result !== exps[k] || n !== 1) begin
                errors++;
                $display("FAIL single_op%0d got %h lat %0d want %h lat 1", ops[k], result, n, exps[k]);
            end
        end
    endtask

`ifdef ALU_MEXT_EN
    task automatic test_mext();
        logic [4:0]  ops  [8] = '{5'd20, 5'd22, 5'd19, 5'd16, 5'd17, 5'd17, 5'd21, 5'd23};
        logic [31:0] as   [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd7,
                                  32'hFFFF_FFFF, 32'h8000_0000, 32'd100, 32'd100};
        logic [31:0] bs   [8] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                  32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'd7};
        logic [31:0] exps [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFEB,
                                  32'h0, 32'h4000_0000, 32'd14, 32'd2};
        int n;
        logic busy_bad;
        for (int k = 0; k < 8; k++) begin
            issue(ops[k], as[k], bs[k], 12'h0, 1'b0);
            n = 1;
            busy_bad = 1'b0;
            while (!out_valid && n < 100) begin
                if (!busy) busy_bad = 1'b1;
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (result !== exps[k] || n !== 33 || busy_bad !== 1'b0) begin
                errors++;
                $display("FAIL mext_op%0d got %h lat %0d busy_drop %0b want %h lat 33 busy_drop 0",
                         ops[k], result, n, busy_bad, exps[k]);
            end
        end
    endtask

    task automatic test_div_special();
        logic [4:0]  ops  [4] = '{5'd21, 5'd22, 5'd20, 5'd23};
        logic [31:0] as   [4] = '{32'd100, 32'h8000_0000, 32'h8000_0000, 32'd100};
        logic [31:0] bs   [4] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exps [4] = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'd100};
        int n;
        for (int k = 0; k < 4; k++) begin
            issue(ops[k], as[k], bs[k], 12'h0, 1'b0);
            wait_valid(n);
            checks++;
            if (result !== exps[k] || n !== 1) begin
                errors++;
                $display("FAIL div_special%0d got %h lat %0d want %h lat 1", ops[k], result, n, exps[k]);
            end
        end
    endtask
`else
    task automatic test_div_special();
        logic [4:0] ops [2] = '{5'd20, 5'd16};
        int n;
        for (int k = 0; k < 2; k++) begin
            issue(ops[k], 32'd100, 32'd7, 12'h0, 1'b0);
            wait_valid(n);
            checks++;
            if (result !== 32'h0 || n !== 1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL no_mext_op%0d got %h lat %0d busy %0b want 0 lat 1 busy 0",
                         ops[k], result, n, busy);
            end
        end
    endtask
`endif

    task automatic test_backpressure();
        int bad;
        idle();
        out_ready = 1'b0;
        issue(5'd0, 32'd5, 32'd4, 12'h0, 1'b0);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid !== 1'b1 || result !== 32'd9 || in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold bad_cycles %0d want 0", bad); end
        op = 5'd9; src_a = 32'd12; src_b = 32'd10; use_imm = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready got %0b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (result !== 32'd8 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_b2b got %h valid %0b want 8 valid 1", result, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd8 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_retire valid %0b result %h ready %0b want 0 8 1", out_valid, result, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        idle();
`ifdef ALU_MEXT_EN
        issue(5'd20, 32'd100, 32'd7, 12'h0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %0b want 1", busy); end
`else
        out_ready = 1'b0;
        issue(5'd0, 32'd3, 32'd4, 12'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (result !== 32'd7) begin errors++; $display("FAIL mid_hold got %h want 7", result); end
`endif
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset valid %0b busy %0b result %h want 0 0 0", out_valid, busy, result);
        end
        out_ready = 1'b1;
        #2 rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %0b want 1", in_ready); end
        @(posedge clk); #1;
        issue(5'd0, 32'd1, 32'd1, 12'h0, 1'b0);
        wait_valid(n);
        checks++;
        if (result !== 32'd2 || n !== 1) begin
            errors++; $display("FAIL mid_after_add got %h lat %0d want 2 lat 1", result, n);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 5'd0; src_a = '0; src_b = '0; imm = '0; use_imm = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_add_sub();
        test_single_ops();
`ifdef ALU_MEXT_EN
        test_mext();
`endif
        test_div_special();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the core's single-cycle one-hot ALU.
- Sits in the execute stage between operand fetch/forwarding and writeback.
- Takes an encoded opcode, two XLEN operands and an optional sign-extended immediate, and returns a registered result over a valid/ready interface.
- RV32I integer ops complete in one cycle; optional M-extension ops (MUL*/DIV*/REM*) run on an iterative datapath.

Parameters:
XLEN, 32, operand/result width; power of two, >= 8
IMM_W, 12, immediate width; sign-extended to XLEN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  ALU can accept operation
op  in  5  opcode: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,16 MUL,17 MULH,18 MULHSU,19 MULHU,20 DIV,21 DIVU,22 REM,23 REMU
src_a  in  XLEN  operand A (rs1)
src_b  in  XLEN  operand B (rs2)
imm  in  IMM_W  immediate
use_imm  in  1  1: operand B = sext(imm), else src_b
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  registered result
busy  out  1  iterative op in progress (state CALC)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, busy=0, in_ready=1, iteration counter=0. Applies immediately, including mid-operation; any in-flight op is discarded with no output.
- States:
  - IDLE: waiting for an op.
  - CALC: iterative op running.
  - DONE: result held until consumed.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Accept = in_valid && in_ready.
- Accepting in DONE with out_ready=1 retires the old result and starts the new op in the same edge (back-to-back throughput 1/cycle for single-cycle ops).
- Operand latch: on accept, A, B (imm mux applied) and op are registered. Later changes on src_a/src_b/op/imm do not affect the op.
- Single-cycle ops (0-9) and undefined opcodes:
  - result registered on the accept edge; out_valid=1 in the next cycle; state→DONE.
  - Undefined opcodes produce result=0.
- Shifts use B[$clog2(XLEN)-1:0] only. SRA is arithmetic; SRL is logical.
- SLT/SLTU: result 1 or 0, zero-extended.
- ADD/SUB wrap modulo 2^XLEN; no overflow flag.
- Iterative ops (16-23):
  - Accept → CALC; run XLEN iterations, one per clock.
  - Last iteration → DONE with result registered; out_valid rises XLEN+1 cycles after the accept edge.
  - Multiply is shift-add on magnitudes, with sign correction per MULH/MULHSU semantics.
  - Divide is restoring on magnitudes; quotient sign = sign(A)^sign(B), remainder sign = sign(A).
- Divide special cases (fast path, single-cycle latency, no CALC):
  - B==0: DIV/DIVU → all ones; REM/REMU → A.
  - Signed overflow (A = -2^(XLEN-1), B = -1): DIV → A; REM → 0.
- DONE:
  - result and out_valid held stable while out_ready=0.
  - out_ready=1 and no new accept → IDLE, out_valid=0 next cycle.
  - result retains its last value after the handshake.
- In CALC: in_ready=0, busy=1, out_valid=0. out_ready is ignored.
- in_valid=1 while in_ready=0: the op is not consumed; the upstream must hold it.

Optional Feature:
ALU_MEXT_EN
- Defined: M-extension ops 16-23, the iterative datapath and the CALC state are present as above.
- Undefined:
  - Opcodes 16-23 are treated as undefined: result=0 with single-cycle latency.
  - CALC state, iteration counter and multiply/divide datapath are not compiled; busy is tied to 0.

Test Plan:
- XLEN=32, ADD src_a=5, src_b=4, use_imm=0 → result=9, out_valid exactly 1 cycle after accept; then SUB src_a=5, imm=12'hFFF, use_imm=1 → result=6.
- SRA src_a=32'h80000000, src_b=32'h24 → result=32'hF8000000 (only shamt 4 used); SLTU 1 vs 32'hFFFFFFFF → 1; SLT same operands → 0.
- ALU_MEXT_EN: DIV -7/2 → 32'hFFFFFFFD and REM → 32'hFFFFFFFF, out_valid 33 cycles after accept with busy high throughout; MULHU 32'hFFFFFFFF×32'hFFFFFFFF → 32'hFFFFFFFE.
- DIVU 100/0 → 32'hFFFFFFFF and REM 32'h80000000/-1 → 0, both with single-cycle latency; without ALU_MEXT_EN, op 20 → result 0 with 1-cycle latency.
- Backpressure: ADD 5+4 with out_ready=0 for 5 cycles → result=9 and out_valid held, in_ready=0; raise out_ready with in_valid=1 (AND 12&10) → retire and accept on the same edge, next result=8.
- Reset mid-operation: assert rst_n=0 10 cycles into a DIV → out_valid, busy and result go to 0 immediately; after release in_ready=1 and the next ADD 1+1 returns 2.
